// File: rtl/lab_pkg.sv
// Shared constants and helpers for the lab decoder blocks.
// onehot3 also serves the 2-to-4 decoders when its result is narrowed.
package lab_pkg;

  localparam int DEC_W = 3;
  localparam int DEC_N = 8;

  // An unknown index shifts to an all-X result, so undefined selects stay visible in simulation.
  function automatic logic [DEC_N-1:0] onehot3(input logic [DEC_W-1:0] idx);
    return DEC_N'(1) << idx;
  endfunction

endpackage

// File: rtl/v3x8_decoder_sync_dec_core.sv
// Combinational decode core: index and enable to a one-hot word.
// With ACTIVE_LOW the whole word is inverted (74x138 style).
module dec_core
  import lab_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic             i_en,
  input  logic [DEC_W-1:0] i_idx,
  output logic [DEC_N-1:0] o_y
);

  logic [DEC_N-1:0] w_hot;

  always_comb begin
    w_hot = '0;
    if (i_en) begin
      w_hot = onehot3(i_idx);
    end
  end

  assign o_y = ACTIVE_LOW ? ~w_hot : w_hot;

endmodule

// File: rtl/v3x8_decoder_sync.sv
// 3-to-8 decoder with an optional registered output stage.
// Reset loads the inactive pattern and takes priority over the enable.
module v3x8_decoder_sync
  import lab_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit OUTPUT_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  output logic [DEC_N-1:0] Y
);

  localparam logic [DEC_N-1:0] INACTIVE = ACTIVE_LOW ? {DEC_N{1'b1}} : {DEC_N{1'b0}};

  logic [DEC_W-1:0] w_idx;
  logic [DEC_N-1:0] w_dec;

  assign w_idx = {A, B, C};

  dec_core #(
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_dec_core (
    .i_en  (en),
    .i_idx (w_idx),
    .o_y   (w_dec)
  );

  generate
    if (OUTPUT_REG) begin : g_reg
      logic [DEC_N-1:0] r_y;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_y <= INACTIVE;
        end else begin
          r_y <= w_dec;
        end
      end

      assign Y = r_y;
    end else begin : g_comb
      assign Y = w_dec;
    end
  endgenerate

endmodule

// File: tb/tb_v3x8_decoder_sync.sv
// Scoreboard bench for the 3-to-8 decoder: registered active-high,
// registered active-low and combinational active-high builds side by side.
module tb_v3x8_decoder_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       A = 1'b0;
  logic       B = 1'b0;
  logic       C = 1'b0;
  logic [7:0] y_hi;
  logic [7:0] y_lo;
  logic [7:0] y_c;

  int checks = 0;
  int failures = 0;

  logic [7:0] q_hi[$];
  logic [7:0] q_lo[$];
  logic [7:0] q_c[$];

  always #5 clk = ~clk;

  v3x8_decoder_sync #(.ACTIVE_LOW(1'b0), .OUTPUT_REG(1'b1)) u_hi (
    .clk(clk), .rst(rst), .en(en), .A(A), .B(B), .C(C), .Y(y_hi)
  );

  v3x8_decoder_sync #(.ACTIVE_LOW(1'b1), .OUTPUT_REG(1'b1)) u_lo (
    .clk(clk), .rst(rst), .en(en), .A(A), .B(B), .C(C), .Y(y_lo)
  );

  v3x8_decoder_sync #(.ACTIVE_LOW(1'b0), .OUTPUT_REG(1'b0)) u_c (
    .clk(clk), .rst(rst), .en(en), .A(A), .B(B), .C(C), .Y(y_c)
  );

  // Drive one vector per cycle at the falling edge and queue the hand-computed results.
  task automatic apply(input logic r, input logic e, input logic [2:0] abc,
                       input logic [7:0] exp_hi, input logic [7:0] exp_lo,
                       input logic [7:0] exp_c);
    @(negedge clk);
    rst = r;
    en  = e;
    {A, B, C} = abc;
    q_hi.push_back(exp_hi);
    q_lo.push_back(exp_lo);
    q_c.push_back(exp_c);
  endtask

  // Registered builds: the result of the last driven vector appears after the rising edge.
  initial begin
    logic [7:0] exp_v;
    forever begin
      @(posedge clk);
      #1;
      if (q_hi.size() > 0) begin
        exp_v = q_hi.pop_front();
        checks++;
        if (y_hi !== exp_v) begin
          failures++;
          $display("FAIL reg_active_high: got %02h expected %02h (rst=%0b en=%0b abc=%0b%0b%0b)",
                   y_hi, exp_v, rst, en, A, B, C);
        end
      end
      if (q_lo.size() > 0) begin
        exp_v = q_lo.pop_front();
        checks++;
        if (y_lo !== exp_v) begin
          failures++;
          $display("FAIL reg_active_low: got %02h expected %02h (rst=%0b en=%0b abc=%0b%0b%0b)",
                   y_lo, exp_v, rst, en, A, B, C);
        end
      end
    end
  end

  // Combinational build: checked mid-cycle, with no rising edge between drive and sample.
  initial begin
    logic [7:0] exp_v;
    forever begin
      @(negedge clk);
      #2;
      if (q_c.size() > 0) begin
        exp_v = q_c.pop_front();
        checks++;
        if (y_c !== exp_v) begin
          failures++;
          $display("FAIL comb_active_high: got %02h expected %02h (rst=%0b en=%0b abc=%0b%0b%0b)",
                   y_c, exp_v, rst, en, A, B, C);
        end
      end
    end
  end

  initial begin
    // Reset held for two cycles, then release with 101 selected.
    apply(1'b1, 1'b1, 3'b101, 8'h00, 8'hFF, 8'h20);
    apply(1'b1, 1'b1, 3'b101, 8'h00, 8'hFF, 8'h20);
    apply(1'b0, 1'b1, 3'b101, 8'h20, 8'hDF, 8'h20);
    // Full sweep.
    apply(1'b0, 1'b1, 3'b000, 8'h01, 8'hFE, 8'h01);
    apply(1'b0, 1'b1, 3'b001, 8'h02, 8'hFD, 8'h02);
    apply(1'b0, 1'b1, 3'b010, 8'h04, 8'hFB, 8'h04);
    apply(1'b0, 1'b1, 3'b011, 8'h08, 8'hF7, 8'h08);
    apply(1'b0, 1'b1, 3'b100, 8'h10, 8'hEF, 8'h10);
    apply(1'b0, 1'b1, 3'b101, 8'h20, 8'hDF, 8'h20);
    apply(1'b0, 1'b1, 3'b110, 8'h40, 8'hBF, 8'h40);
    apply(1'b0, 1'b1, 3'b111, 8'h80, 8'h7F, 8'h80);
    // Enable toggling on 011.
    apply(1'b0, 1'b1, 3'b011, 8'h08, 8'hF7, 8'h08);
    apply(1'b0, 1'b0, 3'b011, 8'h00, 8'hFF, 8'h00);
    apply(1'b0, 1'b1, 3'b011, 8'h08, 8'hF7, 8'h08);
    // 110 decode, disable, and reset (reset does not touch the combinational build).
    apply(1'b0, 1'b1, 3'b110, 8'h40, 8'hBF, 8'h40);
    apply(1'b0, 1'b0, 3'b110, 8'h00, 8'hFF, 8'h00);
    apply(1'b1, 1'b1, 3'b110, 8'h00, 8'hFF, 8'h40);
    apply(1'b1, 1'b0, 3'b010, 8'h00, 8'hFF, 8'h00);
    // Sweep interrupted by reset at 100, then resumed.
    apply(1'b0, 1'b1, 3'b000, 8'h01, 8'hFE, 8'h01);
    apply(1'b0, 1'b1, 3'b001, 8'h02, 8'hFD, 8'h02);
    apply(1'b0, 1'b1, 3'b010, 8'h04, 8'hFB, 8'h04);
    apply(1'b0, 1'b1, 3'b011, 8'h08, 8'hF7, 8'h08);
    apply(1'b1, 1'b1, 3'b100, 8'h00, 8'hFF, 8'h10);
    apply(1'b0, 1'b1, 3'b101, 8'h20, 8'hDF, 8'h20);
    apply(1'b0, 1'b1, 3'b110, 8'h40, 8'hBF, 8'h40);
    apply(1'b0, 1'b1, 3'b111, 8'h80, 8'h7F, 8'h80);
    // Combinational step 001 -> 111 and a final disable on 111.
    apply(1'b0, 1'b1, 3'b001, 8'h02, 8'hFD, 8'h02);
    apply(1'b0, 1'b1, 3'b111, 8'h80, 8'h7F, 8'h80);
    apply(1'b0, 1'b0, 3'b111, 8'h00, 8'hFF, 8'h00);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q_hi.size() + q_lo.size() + q_c.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0",
               q_hi.size() + q_lo.size() + q_c.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
